bcd_serial_subtractor: RTL and testbench
========================================

BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  subtrahend, packed BCD, same layout.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 done  output  1  one-cycle pulse when a result is valid.
REQ-009 diff  output  4*DIGITS  magnitude of a-b, packed BCD.
REQ-010 neg  output  1  high when a<b.
REQ-011 err  output  1  invalid input digit detected; see REQ-027.

Function
REQ-012 The block SHALL compute |a-b| digit-serially, one digit per clock, LSD first, using 9's complement of b plus an initial carry of 1 (10's complement).
REQ-013 The FSM SHALL have states IDLE, ADD, FIX, DONE.
REQ-014 If start=1 in IDLE at edge k, a and b SHALL be captured and the state SHALL become ADD; the digit index SHALL be cleared and carry set to 1.
REQ-015 ADD: each edge SHALL add a digit, (9-b digit) and carry with decimal correction (sum>9 -> subtract 10, carry 1), then store the sum digit.
REQ-016 After the last ADD digit (edge k+DIGITS), carry-out 1 SHALL go to DONE with neg=0, and carry-out 0 SHALL go to FIX.
REQ-017 FIX SHALL run DIGITS edges, replacing each stored digit with (9-digit)+carry, initial carry 1, decimal-corrected, then go to DONE with neg=1.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle after edge k+DIGITS for positive or equal results, and after edge k+2*DIGITS for negative results.
REQ-020 diff, neg and err SHALL update only on the transition into DONE and hold until the next DONE or reset.
REQ-021 start while busy=1 SHALL be ignored, with no effect on captured operands.
REQ-022 a==b SHALL produce diff=0 and neg=0, never negative zero.
REQ-023 The digit index SHALL wrap to 0 when entering FIX, and no digit SHALL be processed twice in one phase.

Reset
REQ-024 rst_n=0 at any edge SHALL force IDLE, clear the digit index and carry, and set busy=0, done=0, diff=0, neg=0, err=0.
REQ-025 Reset during ADD or FIX SHALL abandon the operation without producing done.
REQ-026 start SHALL be honoured on the first edge with rst_n=1.

Configuration
REQ-027 With macro BCD_SUB_ERR_CHECK_EN defined, any digit of a or b greater than 9 at capture SHALL send the FSM directly IDLE->DONE at edge k+1 with err=1, diff=0, neg=0.
REQ-028 Without BCD_SUB_ERR_CHECK_EN, err SHALL be tied to 0 and invalid digits SHALL be processed unchecked through REQ-015..017.

Structure
REQ-029 Package bcd_pkg SHALL hold the FSM state enum, the 4-bit digit typedef, and constants DIGIT_MAX=9 and DIGIT_RADIX=10.
REQ-030 A combinational sub-module bcd_digit_adder (digit, digit, carry-in -> digit, carry-out, decimal-corrected) SHALL be instantiated once and shared by ADD and FIX.
REQ-031 The RTL SHALL contain no multi-digit combinational adder; only one digit path is permitted.

Verification (DIGITS=4)
REQ-032 a=5432, b=1234, start at edge k -> done after edge k+4, diff=4198, neg=0, err=0.
REQ-033 a=1234, b=5432 -> done after edge k+8, diff=4198, neg=1.
REQ-034 a=9999, b=9999 -> diff=0000, neg=0; also a=0000, b=0001 -> diff=0001, neg=1.
REQ-035 start pulsed again during ADD with different operands -> ignored; first result delivered unchanged, busy stays high throughout.
REQ-036 rst_n=0 at edge k+2 of an ADD -> all outputs 0 next cycle, no done; a fresh start then completes correctly.
REQ-037 With macro, a=00A0 -> done after edge k+1, err=1, diff=0; without macro, err stays 0 and done follows REQ-019.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {StIdle, StAdd, StFix, StDone} state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX   = 4'd9;
  localparam digit_t DIGIT_RADIX = 4'd10;

  // 9's complement of a single BCD digit
  function automatic digit_t nines(input digit_t d);
    return DIGIT_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal correction; the only arithmetic path in the subtractor.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (raw > {1'b0, DIGIT_MAX}) begin
      cout = 1'b1;
      // Low nibble minus the radix equals (raw - radix) modulo 16
      sum  = raw[3:0] - DIGIT_RADIX;
    end else begin
      cout = 1'b0;
      sum  = raw[3:0];
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD |a-b| via 10's complement, with a complement pass for negative results.
// Optional input digit checking is enabled with macro BCD_SUB_ERR_CHECK_EN.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, b_q, acc_q, acc_nxt;
  logic [4*DIGITS-1:0] diff_q;
  logic [IdxW-1:0]     idx_q;
  logic                carry_q, neg_q;
  logic                last, abort;
  digit_t              op_x, op_y, sum;
  logic                cout;

`ifdef BCD_SUB_ERR_CHECK_EN
  logic inv_q, err_q;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > DIGIT_MAX) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign abort = inv_q;
  assign err   = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  assign last = (idx_q == LastIdx);

  // Single shared digit path: ADD uses a + 9's(b), FIX uses 9's(acc) + 0
  always_comb begin
    op_x = a_q[{idx_q, 2'b00} +: 4];
    op_y = nines(b_q[{idx_q, 2'b00} +: 4]);
    if (state_q == StFix) begin
      op_x = nines(acc_q[{idx_q, 2'b00} +: 4]);
      op_y = '0;
    end
  end

  bcd_digit_adder u_adder (
    .x    (op_x),
    .y    (op_y),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    acc_nxt = acc_q;
    acc_nxt[{idx_q, 2'b00} +: 4] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StAdd;
      StAdd: begin
        if (abort)     state_d = StDone;
        else if (last) state_d = cout ? StDone : StFix;
      end
      StFix:  if (last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      neg_q   <= 1'b0;
`ifdef BCD_SUB_ERR_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: if (start) begin
          a_q     <= a;
          b_q     <= b;
          acc_q   <= '0;
          idx_q   <= '0;
          carry_q <= 1'b1;
`ifdef BCD_SUB_ERR_CHECK_EN
          inv_q   <= has_bad_digit(a) | has_bad_digit(b);
`endif
        end
        StAdd: begin
          if (abort) begin
            diff_q <= '0;
            neg_q  <= 1'b0;
`ifdef BCD_SUB_ERR_CHECK_EN
            err_q  <= 1'b1;
`endif
          end else begin
            acc_q   <= acc_nxt;
            idx_q   <= idx_q + 1'b1;
            carry_q <= cout;
            if (last) begin
              if (cout) begin
                diff_q <= acc_nxt;
                neg_q  <= 1'b0;
`ifdef BCD_SUB_ERR_CHECK_EN
                err_q  <= 1'b0;
`endif
              end else begin
                // Borrow out: result is negative, start the complement pass
                idx_q   <= '0;
                carry_q <= 1'b1;
              end
            end
          end
        end
        StFix: begin
          acc_q   <= acc_nxt;
          idx_q   <= idx_q + 1'b1;
          carry_q <= cout;
          if (last) begin
            diff_q <= acc_nxt;
            neg_q  <= 1'b1;
`ifdef BCD_SUB_ERR_CHECK_EN
            err_q  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (DIGITS=4): directed vectors, monitor on done.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, neg, err;
  logic [15:0] diff;

  typedef struct {
    logic [15:0] diff;
    logic        neg;
    logic        err;
    int          done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no result at edge %0d", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", {16'h0, diff}, {16'h0, e.diff});
        check("neg", {31'h0, neg}, {31'h0, e.neg});
        check("err", {31'h0, err}, {31'h0, e.err});
        check("latency_edge", edge_cnt, e.done_edge);
      end
    end
  end

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ed,
                       input logic en, input logic ee, input int lat);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    e.diff = ed;
    e.neg = en;
    e.err = ee;
    e.done_edge = edge_cnt + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'h0, busy, done, neg, err, diff}, 32'h0);

    // Start on the very first edge with reset released
    a = 16'h5432;
    b = 16'h1234;
    start = 1'b1;
    rst_n = 1'b1;
    e.diff = 16'h4198;
    e.neg = 1'b0;
    e.err = 1'b0;
    e.done_edge = edge_cnt + 1 + 4;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("diff_hold", {16'h0, diff}, 32'h4198);

    issue(16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8);
    wait_idle();
    issue(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4);
    wait_idle();
    issue(16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8);
    wait_idle();
    issue(16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, 4);
    wait_idle();

    // Start pulsed during ADD with other operands must be ignored
    issue(16'h5000, 16'h0001, 16'h4999, 1'b0, 1'b0, 4);
    check("busy_add0", {31'h0, busy}, 32'h1);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_during_op", {31'h0, busy}, 32'h1);
      @(negedge clk);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check("idle_after_ignored_start", {31'h0, busy}, 32'h0);

    // Reset at edge k+2 of an ADD: no done, outputs cleared
    @(negedge clk);
    a = 16'h3333;
    b = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {11'h0, busy, done, neg, err, diff}, 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_reset_no_done_busy", {30'h0, busy, done}, 32'h0);
    issue(16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, 4);
    wait_idle();

    // Invalid digit
`ifdef BCD_SUB_ERR_CHECK_EN
    issue(16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1);
`else
    issue(16'h00A0, 16'h0000, 16'h00A0, 1'b0, 1'b0, 4);
`endif
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
